// File: rtl/bram_fifo.sv
// Single-clock FIFO on an inferred dual-port RAM with occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module bram_fifo #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DATA_LEN      = 256,
  parameter int unsigned AFULL_THRESH  = DATA_LEN - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_en,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic                          r_en,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic                          r_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DATA_LEN):0]     count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned AW = $clog2(DATA_LEN);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DATA_LEN];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_ovf;
  logic                  r_udf;

  logic w_full;
  logic w_empty;
  logic w_wacc;
  logic w_racc;

  assign w_full  = (r_count == CW'(DATA_LEN));
  assign w_empty = (r_count == '0);
  assign w_wacc  = w_en & ~w_full;
  assign w_racc  = r_en & ~w_empty;

  // RAM write port; contents deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && w_wacc)
      r_mem[r_wptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wacc)
        r_wptr <= r_wptr + AW'(1);
      if (w_racc) begin
        r_rdata <= r_mem[r_rptr];
        r_rptr  <= r_rptr + AW'(1);
      end
      r_rvalid <= w_racc;
      case ({w_wacc, w_racc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_en && w_full)
        r_ovf <= 1'b1;
      if (r_en && w_empty)
        r_udf <= 1'b1;
    end
  end

  assign r_data       = r_rdata;
  assign r_valid      = r_rvalid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (32'(r_count) >= AFULL_THRESH);
  assign almost_empty = (32'(r_count) <= AEMPTY_THRESH);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo (16-bit x 8 deep, thresholds 4/2): stimulus
// pushes expected read data, a negedge monitor pops it whenever r_valid is seen.
module tb_bram_fifo;

  logic        clk;
  logic        rst;
  logic        w_en;
  logic [15:0] w_data;
  logic        r_en;
  logic [15:0] r_data;
  logic        r_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  bram_fifo #(
    .DATA_WIDTH   (16),
    .DATA_LEN     (8),
    .AFULL_THRESH (4),
    .AEMPTY_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_en        (w_en),
    .w_data      (w_data),
    .r_en        (r_en),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic        mrv  = 1'b0;
  logic [15:0] mrd  = '0;
  logic        movf = 1'b0;
  logic        mudf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got r_data %0h expected no r_valid", r_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (r_data !== e) begin
          fails++;
          $display("FAIL mon_data: got %0h expected %0h", r_data, e);
        end
      end
    end
  end

  task automatic cycle(input logic rs, input logic we, input logic [15:0] wd, input logic re);
    logic mw, mr;
    rst = rs; w_en = we; w_data = wd; r_en = re;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      mrv = 1'b0; mrd = '0; movf = 1'b0; mudf = 1'b0;
    end else begin
      mw = we && (model_q.size() != 8);
      mr = re && (model_q.size() != 0);
      if (we && model_q.size() == 8) movf = 1'b1;
      if (re && model_q.size() == 0) mudf = 1'b1;
      mrv = mr;
      if (mr) begin
        mrd = model_q.pop_front();
        exp_q.push_back(mrd);
      end
      if (mw) model_q.push_back(wd);
    end
    #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic check_state(input string name);
    int n;
    n = model_q.size();
    chk({name, "/count"},  32'(count),        32'(n));
    chk({name, "/full"},   32'(full),         32'(n == 8));
    chk({name, "/empty"},  32'(empty),        32'(n == 0));
    chk({name, "/afull"},  32'(almost_full),  32'(n >= 4));
    chk({name, "/aempty"}, 32'(almost_empty), 32'(n <= 2));
    chk({name, "/ovf"},    32'(overflow),     32'(movf));
    chk({name, "/udf"},    32'(underflow),    32'(mudf));
    chk({name, "/rvalid"}, 32'(r_valid),      32'(mrv));
    chk({name, "/rdata"},  32'(r_data),       32'(mrd));
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; w_data = '0; r_en = 1'b0;

    // Reset then idle
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    check_state("reset");
    chk("reset_empty",  32'(empty), 32'd1);
    chk("reset_aempty", 32'(almost_empty), 32'd1);
    chk("reset_rdata",  32'(r_data), 32'h0);

    // Fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 16'(i), 1'b0);
      check_state("fill");
      if (i == 2) chk("fill2_aempty", 32'(almost_empty), 32'd1);
      if (i == 3) chk("fill3_aempty", 32'(almost_empty), 32'd0);
      if (i == 3) chk("fill3_afull",  32'(almost_full), 32'd0);
      if (i == 4) chk("fill4_afull",  32'(almost_full), 32'd1);
      if (i == 7) chk("fill7_full",   32'(full), 32'd0);
    end
    chk("fill8_full",  32'(full), 32'd1);
    chk("fill8_count", 32'(count), 32'd8);

    // Overflow: write while full must be dropped
    cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
    check_state("ovf");
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag",  32'(overflow), 32'd1);

    // Drain 8 words
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      check_state("drain");
      chk("drain_data", 32'(r_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow: read while empty
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check_state("udf");
    chk("udf_rvalid", 32'(r_valid), 32'd0);
    chk("udf_flag",   32'(underflow), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("sticky_ovf", 32'(overflow), 32'd1);
    chk("sticky_udf", 32'(underflow), 32'd1);
    check_state("sticky");

    // Simultaneous read/write at full
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'(16'h10 + i), 1'b0);
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
    check_state("simfull");
    chk("simfull_count", 32'(count), 32'd7);
    chk("simfull_data",  32'(r_data), 32'h10);
    chk("simfull_ovf",   32'(overflow), 32'd1);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("simfull_drain", 32'(r_data), 32'(16'h10 + i));
    end
    check_state("simfull_drained");

    // Simultaneous read/write at empty: write only, no bypass
    cycle(1'b0, 1'b1, 16'h00AA, 1'b1);
    check_state("simempty");
    chk("simempty_count",  32'(count), 32'd1);
    chk("simempty_rvalid", 32'(r_valid), 32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    chk("simempty_read", 32'(r_data), 32'h00AA);
    check_state("simempty_read");

    // Wrap-around streaming at count=3
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'(16'h100 + i), 1'b0);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b1, 16'(16'h200 + i), 1'b1);
      chk("stream_count", 32'(count), 32'd3);
      if (i < 3) chk("stream_data", 32'(r_data), 32'(16'h100 + i));
      else       chk("stream_data", 32'(r_data), 32'(16'h200 + i - 3));
    end
    check_state("stream");
    chk("stream_ovf", 32'(overflow), 32'd0);
    chk("stream_udf", 32'(underflow), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check_state("stream_drained");

    // Mid-stream reset with simultaneous requests
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'(16'h300 + i), 1'b0);
    chk("mid_count5", 32'(count), 32'd5);
    cycle(1'b1, 1'b1, 16'h5555, 1'b1);
    check_state("midrst");
    chk("midrst_count",  32'(count), 32'd0);
    chk("midrst_empty",  32'(empty), 32'd1);
    chk("midrst_rvalid", 32'(r_valid), 32'd0);
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    chk("midrst_read", 32'(r_data), 32'h1234);
    check_state("midrst_read");

    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
Single-clock synchronous FIFO built on an inferred dual-port block RAM, with parametrised width and depth. It adds what the plain RAM lacks: pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between producer and consumer logic as the standard buffering primitive for streaming data.

Parameters:
DATA_WIDTH, 16, width of each stored word in bits (>=1)
DATA_LEN, 256, depth in words; must be a power of two, >=4
AFULL_THRESH, DATA_LEN-4, almost_full asserts when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserts when count <= AEMPTY_THRESH

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  synchronous reset, active high
w_en  input  1  write request
w_data  input  DATA_WIDTH  write data
r_en  input  1  read request
r_data  output  DATA_WIDTH  read data, registered
r_valid  output  1  r_data holds a newly read word this cycle
full  output  1  count == DATA_LEN
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DATA_LEN)+1  current occupancy
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All state updates on the rising edge of clk. Memory is an inferred RAM: one write port and one registered read port. Memory contents are not reset.
- Reset (rst=1 at an edge): w_ptr=0, r_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0. Flags then read empty=1, full=0, almost_empty=1, almost_full=0.
- Reset wins over any simultaneous w_en/r_en. A mid-stream reset discards all contents. The first read after reset returns data written after reset.
- Write acceptance: w_acc = w_en & ~full. If accepted, mem[w_ptr] <= w_data and w_ptr increments.
- Read acceptance: r_acc = r_en & ~empty. If accepted, r_data <= mem[r_ptr], r_ptr increments, and r_valid=1 on the next cycle.
- If no read is accepted, r_valid=0 on the next cycle and r_data holds its last value.
- Read latency is 1 cycle: r_en at edge N gives r_data/r_valid valid after edge N.
- Pointers are $clog2(DATA_LEN) bits wide and wrap naturally from DATA_LEN-1 to 0.
- count update by case:
  - w_acc & ~r_acc: count+1
  - r_acc & ~w_acc: count-1
  - both or neither: unchanged
- Flags are decoded from the registered count, so they update in the same cycle as count.
- Simultaneous w_en & r_en:
  - When full: the read is accepted and the write is rejected (no pass-through); overflow sets. count goes DATA_LEN -> DATA_LEN-1.
  - When empty: the write is accepted and the read is rejected; underflow sets. r_valid=0 next cycle. The written word is not bypassed to r_data.
  - Otherwise both are accepted. The read and write addresses never collide because count is in 1..DATA_LEN-1.
- overflow is set by w_en & full; underflow is set by r_en & empty. Both stay set until rst.
- Rejected operations never modify the memory, pointers or count.

Test Plan:
- Reset then idle: rst high 2 cycles -> count=0, empty=1, almost_empty=1, full=0, r_valid=0, r_data=0, overflow=underflow=0.
- Fill/drain (DATA_WIDTH=16, DATA_LEN=8, thresholds 4/2): write 0x0001..0x0008 -> after the 4th write almost_full=1; after the 8th write full=1, count=8. Then read 8 words -> r_valid each cycle after r_en, data 0x0001..0x0008 in order; empty=1 after the last read.
- Overflow/underflow: when full, w_en=1 with 0xDEAD -> count stays 8, overflow=1, 0xDEAD is never read out. When empty, r_en=1 -> r_valid=0 next cycle, underflow=1. Both flags persist until rst.
- Simultaneous at boundaries: full with w_en=r_en=1 -> count=7, read returns the oldest word, overflow=1. Empty with w_en=r_en=1 (data 0x00AA) -> count=1, r_valid=0; the next read returns 0x00AA.
- Wrap-around streaming: write and read every cycle for 3*DATA_LEN cycles at count=3 -> count stays 3, output sequence equals input sequence delayed by 3 accepted writes, no error flags set.
- Mid-stream reset: count=5, assert rst with w_en=r_en=1 -> next cycle count=0, empty=1, r_valid=0. Write 0x1234 then read -> r_data=0x1234.
